// File: rtl/autofire_ctrl.sv
// autofire_ctrl: per-button NES autofire with a SELECT+button hotkey and one shared,
// rate-selectable fire tick; non-autofire buttons pass through with one cycle of latency.
module autofire_ctrl #(
    parameter int         FREQ        = 37_800_000,
    parameter int         RATE0       = 5,
    parameter int         RATE1       = 10,
    parameter int         RATE2       = 15,
    parameter int         RATE3       = 30,
    parameter logic [7:0] TOGGLE_MASK = 8'b0000_0011,
    parameter logic [7:0] AF_DEFAULT  = 8'b0000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] btn_in,
    input  logic [1:0] rate_sel,
    output logic [7:0] btn_out,
    output logic [7:0] af_en,
    output logic       tick
);
    localparam int D0   = FREQ / RATE0 / 2;
    localparam int D1   = FREQ / RATE1 / 2;
    localparam int D2   = FREQ / RATE2 / 2;
    localparam int D3   = FREQ / RATE3 / 2;
    localparam int D01  = D0 > D1 ? D0 : D1;
    localparam int D23  = D2 > D3 ? D2 : D3;
    localparam int DMAX = D01 > D23 ? D01 : D23;
    localparam int TW   = $clog2(DMAX);
    localparam logic [TW-1:0] L0 = TW'(D0 - 1);
    localparam logic [TW-1:0] L1 = TW'(D1 - 1);
    localparam logic [TW-1:0] L2 = TW'(D2 - 1);
    localparam logic [TW-1:0] L3 = TW'(D3 - 1);
    localparam logic [7:0] NO_SEL  = 8'b1111_1011;
    localparam logic [7:0] HK_MASK = TOGGLE_MASK & NO_SEL;

    if (D0 < 2 || D1 < 2 || D2 < 2 || D3 < 2) begin : g_bad_rate
        $error("autofire_ctrl: every half period must be at least 2 clocks");
    end

    logic [TW-1:0] timer_q, timer_d, last;
    logic [1:0]    rate_q;
    logic          tick_q, tick_d, chg, wrap;
    logic [7:0]    prev_q, af_q, af_d, out_q, out_d, rise, hk, eff, fire;

    // out_q doubles as each button's phase: a held autofire button outputs its phase.
    always_comb begin
        last    = rate_q == 2'd0 ? L0 : rate_q == 2'd1 ? L1 : rate_q == 2'd2 ? L2 : L3;
        chg     = rate_sel != rate_q;
        wrap    = timer_q == last;
        timer_d = (chg || wrap) ? '0 : timer_q + 1'b1;
        tick_d  = wrap && !chg;
        rise    = btn_in & ~prev_q;
        hk      = rise & HK_MASK & {8{btn_in[2]}};
        af_d    = af_q ^ hk;
        eff     = af_q & NO_SEL;
        fire    = btn_in & eff & ~rise;
        out_d   = (btn_in & ~fire) | (fire & (tick_q ? ~out_q : out_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            rate_q  <= rate_sel;
            tick_q  <= 1'b0;
            prev_q  <= '0;
            af_q    <= AF_DEFAULT;
            out_q   <= '0;
        end else begin
            timer_q <= timer_d;
            rate_q  <= rate_sel;
            tick_q  <= tick_d;
            prev_q  <= btn_in;
            af_q    <= af_d;
            out_q   <= out_d;
        end
    end

    assign btn_out = out_q;
    assign af_en   = af_q;
    assign tick    = tick_q;
endmodule
